// File: rtl/sr_pkg.sv
// Shared definitions for the SR command generator: the FSM state encoding
// and the widths of the debounce, pulse and conflict counters.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int DB_CNT_W       = 8;  // holds DB_CYCLES-1 for DB_CYCLES up to 255
  localparam int PULSE_CNT_W    = 4;  // holds PULSE_LEN-1 for PULSE_LEN up to 15
  localparam int CONFLICT_CNT_W = 8;

  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

endpackage

// File: rtl/sr_debounce.sv
// Synchroniser + debouncer for one raw asynchronous input. Produces a
// one-cycle registered event on each debounced 0->1 transition.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_deb;
  logic [DB_CNT_W-1:0] r_cnt;
  logic                r_rise;

  // Two-flop synchroniser, stability counter and debounced level with rise event.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
        r_deb  <= r_sync2;
        r_cnt  <= '0;
        r_rise <= r_sync2;  // only a 0->1 change produces an event
      end else begin
        r_cnt <= r_cnt + DB_CNT_W'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sr_cmd_gen.sv
// SR command generator: debounces set/clear requests and issues mutually
// exclusive, fixed-length S/R pulses separated by a one-cycle gap.
// Optional feature macro: SR_CMD_GEN_CONFLICT_CNT_EN adds an 8-bit
// saturating conflict counter output (conflict_cnt).
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  logic                   w_set_ev;
  logic                   w_clr_ev;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [PULSE_CNT_W-1:0] r_pcnt;
  logic [PULSE_CNT_W-1:0] w_pcnt_next;
  logic                   r_pend_s;
  logic                   r_pend_r;
  logic                   w_pend_s_next;
  logic                   w_pend_r_next;
  logic                   w_conflict_next;
  logic                   w_want_s;
  logic                   w_want_r;
  logic                   r_s;
  logic                   r_r;
  logic                   r_conflict;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (set_in),
    .o_rise (w_set_ev)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (clr_in),
    .o_rise (w_clr_ev)
  );

  assign w_want_s = w_set_ev | r_pend_s;
  assign w_want_r = w_clr_ev | r_pend_r;

  // Next-state, pulse counter, pending flags and conflict decision.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_pcnt_next     = r_pcnt;
    w_pend_s_next   = r_pend_s;
    w_pend_r_next   = r_pend_r;
    w_conflict_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_want_s && w_want_r) begin
          w_pend_s_next   = 1'b0;
          w_pend_r_next   = 1'b0;
          w_conflict_next = 1'b1;
        end else if (w_want_s) begin
          w_state_next  = PULSE_S;
          w_pcnt_next   = '0;
          w_pend_s_next = 1'b0;
        end else if (w_want_r) begin
          w_state_next  = PULSE_R;
          w_pcnt_next   = '0;
          w_pend_r_next = 1'b0;
        end
      end
      PULSE_S, PULSE_R: begin
        w_pend_s_next = r_pend_s | w_set_ev;
        w_pend_r_next = r_pend_r | w_clr_ev;
        if (r_pcnt == PULSE_CNT_W'(PULSE_LEN - 1)) begin
          w_state_next = GAP;
        end else begin
          w_pcnt_next = r_pcnt + PULSE_CNT_W'(1);
        end
      end
      GAP: begin
        w_pend_s_next = r_pend_s | w_set_ev;
        w_pend_r_next = r_pend_r | w_clr_ev;
        w_state_next  = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register and registered command/conflict outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pcnt     <= w_pcnt_next;
      r_pend_s   <= w_pend_s_next;
      r_pend_r   <= w_pend_r_next;
      r_s        <= (w_state_next == PULSE_S);
      r_r        <= (w_state_next == PULSE_R);
      r_conflict <= w_conflict_next;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = (r_state != IDLE);
  assign conflict = r_conflict;

`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

  // Saturating count of conflict pulses, updated together with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict_next && (r_conflict_cnt != CONFLICT_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_W'(1);
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen (DB_CYCLES=4, PULSE_LEN=2): directed
// vector table, hand-written reset/conflict sequences and a randomized run
// against a cycle-level behavioural model. Honours SR_CMD_GEN_CONFLICT_CNT_EN.
module tb_sr_cmd_gen;

  localparam int DB = 4;
  localparam int PL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic S, R, busy, conflict;
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  sr_cmd_gen #(.DB_CYCLES(DB), .PULSE_LEN(PL)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_in   (set_in),
    .clr_in   (clr_in),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .conflict (conflict)
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Debounce as "count of consecutive differing synchronised samples";
  // command as "remaining busy cycles" (PULSE_LEN command cycles + 1 gap).
  bit model_on = 1'b0;
  int m_s1[2], m_s2[2], m_deb[2], m_run[2], m_ev[2], m_pend[2];
  int m_rem, m_cmd, m_conf, m_cnt;

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 0; m_run[k] = 0; m_ev[k] = 0; m_pend[k] = 0;
    end
    m_rem = 0; m_cmd = 0; m_conf = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit raw_s, input bit raw_c, input bit rst_v);
    int raw[2];
    int ws, wr;
    if (rst_v) begin
      model_clear();
      return;
    end
    raw[0] = raw_s; raw[1] = raw_c;
    m_conf = 0;
    if (m_rem == 0) begin
      ws = m_ev[0] | m_pend[0];
      wr = m_ev[1] | m_pend[1];
      if (ws != 0 && wr != 0) begin
        m_conf = 1; m_pend[0] = 0; m_pend[1] = 0;
      end else if (ws != 0) begin
        m_rem = PL + 1; m_cmd = 1; m_pend[0] = 0;
      end else if (wr != 0) begin
        m_rem = PL + 1; m_cmd = 2; m_pend[1] = 0;
      end
    end else begin
      m_pend[0] |= m_ev[0];
      m_pend[1] |= m_ev[1];
      m_rem--;
    end
    if (m_conf != 0 && m_cnt < 255) m_cnt++;
    for (int k = 0; k < 2; k++) begin
      int ev_n;
      ev_n = 0;
      if (m_s2[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_deb[k] = m_s2[k];
          m_run[k] = 0;
          ev_n = m_deb[k];
        end
      end else begin
        m_run[k] = 0;
      end
      m_ev[k] = ev_n;
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step(set_in, clr_in, rst);
    #1;
  endtask

  // Reset for two edges with the given raw levels, release between edges.
  task automatic do_reset(input bit s_lvl, input bit c_lvl);
    rst = 1'b1;
    set_in = s_lvl;
    clr_in = c_lvl;
    repeat (2) @(posedge clk);
    #1;
    check("rst_S", S, 0);
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_conflict", conflict, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit do_rst;
    bit s_in;
    bit c_in;
    bit exp_s;
    bit exp_r;
    bit exp_busy;
    bit exp_conf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit dr, input bit si, input bit ci,
                              input bit es, input bit er, input bit eb, input bit ec);
    vec_t v;
    v.do_rst = dr; v.s_in = si; v.c_in = ci;
    v.exp_s = es; v.exp_r = er; v.exp_busy = eb; v.exp_conf = ec;
    vecs.push_back(v);
  endfunction

  initial begin
    int hold[2];
    bit val[2];

    // Set held from edge 1: S at edges 7-8, busy 7-9, idle at 10.
    for (int e = 1; e <= 11; e++)
      add(e == 1, 1, 0, (e == 7 || e == 8), 0, (e >= 7 && e <= 9), 0);
    // Three-cycle glitch on set: nothing happens.
    for (int e = 1; e <= 12; e++)
      add(e == 1, (e <= 3), 0, 0, 0, 0, 0);
    // Clear event lands during PULSE_S: S 7-8, GAP 9, IDLE 10, R 11-12, GAP 13.
    for (int e = 1; e <= 15; e++)
      add(e == 1, 1, (e >= 2), (e == 7 || e == 8), (e == 11 || e == 12),
          ((e >= 7 && e <= 9) || (e >= 11 && e <= 13)), 0);
    // Simultaneous rise: one conflict pulse at edge 7, no command.
    for (int e = 1; e <= 10; e++)
      add(e == 1, 1, 1, 0, 0, 0, (e == 7));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset(0, 0);
      set_in = vecs[i].s_in;
      clr_in = vecs[i].c_in;
      tick();
      check($sformatf("vec%0d_S", i), S, vecs[i].exp_s);
      check($sformatf("vec%0d_R", i), R, vecs[i].exp_r);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_conflict", i), conflict, vecs[i].exp_conf);
    end
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
    check("conflict_cnt_one", conflict_cnt, 1);
`endif

    // Reset asserted mid-cycle during PULSE_R with a set pending.
    do_reset(0, 0);
    clr_in = 1'b1;
    tick();                   // edge 1
    set_in = 1'b1;            // set event arrives while R pulse is active
    repeat (7) tick();        // edges 2..8
    check("midrst_R_before", R, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_R_async", R, 0);
    check("midrst_S_async", S, 0);
    check("midrst_busy_async", busy, 0);
    set_in = 1'b0;
    clr_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int e = 1; e <= 14; e++) begin
        tick();
        if (S || R || busy) bad++;
      end
      check("midrst_no_pending_served", bad, 0);
    end

    // Input already high across reset release goes through the normal path.
    do_reset(1, 0);
    repeat (6) tick();
    check("hold_rel_S_edge6", S, 0);
    tick();
    check("hold_rel_S_edge7", S, 1);
    check("hold_rel_busy_edge7", busy, 1);

`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
    // 300 conflicts: counter saturates at 255.
    do_reset(0, 0);
    for (int n = 0; n < 300; n++) begin
      set_in = 1'b1; clr_in = 1'b1;
      repeat (8) tick();
      set_in = 1'b0; clr_in = 1'b0;
      repeat (8) tick();
      if (n == 253) check("conflict_cnt_254", conflict_cnt, 254);
    end
    check("conflict_cnt_sat", conflict_cnt, 255);
`endif

    // Randomized run against the behavioural model.
    model_clear();
    model_on = 1'b1;
    do_reset(0, 0);
    hold[0] = 0; hold[1] = 0; val[0] = 0; val[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (hold[k] == 0) begin
          val[k] = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 10);
        end
        hold[k]--;
      end
      set_in = val[0];
      clr_in = val[1];
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_clear();
        #1;
        check("rnd_async_rst_S", S, 0);
        check("rnd_async_rst_R", R, 0);
      end else begin
        rst = 1'b0;
      end
      tick();
      check("rnd_S", S, (m_cmd == 1 && m_rem > 1));
      check("rnd_R", R, (m_cmd == 2 && m_rem > 1));
      check("rnd_busy", busy, (m_rem > 0));
      check("rnd_conflict", conflict, m_conf);
      check("rnd_not_both", S & R, 0);
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
      check("rnd_conflict_cnt", conflict_cnt, m_cnt);
`endif
    end
    rst = 1'b0;
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
